// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Purpose : Shared encodings for the MIPS fetch stage: next-PC select codes,
//           fetch FSM state encoding, default reset PC and an alignment helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Next-PC select codes driven by the controller
  localparam logic [1:0] NPC_SEQ = 2'b00;  // pc + 4
  localparam logic [1:0] NPC_JR  = 2'b01;  // register Rs
  localparam logic [1:0] NPC_BR  = 2'b10;  // conditional PC-relative branch
  localparam logic [1:0] NPC_JMP = 2'b11;  // j / jal pseudo-absolute target

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/npc_calc.sv
`default_nettype none
// ============================================================================
// Module  : npc_calc
// Purpose : Combinational next-PC generator for the fetch stage.
// Ports   : pc           in  32  address of the current instruction
//           instr        in  32  current instruction word
//           npc_sel      in  2   next-PC select (seq / jr / branch / jump)
//           branch_taken in  1   branch condition, used only for NPC_BR
//           rs_val       in  32  register Rs value for jr
//           npc          out 32  next program counter
// Revision: 1.0 - initial release
// ============================================================================
module npc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [1:0]  npc_sel,
  input  logic        branch_taken,
  input  logic [31:0] rs_val,
  output logic [31:0] npc
);

  logic [31:0] w_pc4;
  logic [31:0] w_br_off;
  logic [31:0] w_br_tgt;
  logic [31:0] w_jmp_tgt;
  logic        unused_opcode;

  // All sums are 32 bits wide; carry out is dropped so addresses wrap.
  assign w_pc4     = pc + 32'd4;
  // Sign-extended 16-bit word offset, shifted to a byte offset.
  assign w_br_off  = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign w_br_tgt  = w_pc4 + w_br_off;
  // Jump target keeps the 256 MB region of the delay-slot address.
  assign w_jmp_tgt = {w_pc4[31:28], instr[25:0], 2'b00};

  // Opcode field is decoded elsewhere; not needed for target formation.
  assign unused_opcode = ^instr[31:26];

  always_comb begin
    npc = w_pc4;
    case (npc_sel)
      NPC_SEQ: npc = w_pc4;
      NPC_JR:  npc = rs_val;
      NPC_BR:  npc = branch_taken ? w_br_tgt : w_pc4;
      NPC_JMP: npc = w_jmp_tgt;
      default: npc = w_pc4;
    endcase
  end

endmodule : npc_calc
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : pc_fetch_unit
// Purpose : Instruction-fetch stage. Holds the PC, fetches one word from
//           variable-latency imem over req/rvalid, presents it to decode and
//           waits for exec_done before applying the selected next PC.
// Ports   : clk, rst          clock, synchronous active-high reset
//           imem_req/addr     fetch request (held until rvalid) and address
//           imem_rvalid/rdata returned instruction word
//           instr_valid/instr/pc  instruction presented to decode
//           exec_done         current instruction retires this cycle
//           npc_sel, branch_taken, rs_val  next-PC controls (with exec_done)
//           fetch_fault       sticky misaligned-next-PC flag
//           retired_cnt       wrapping count of retired instructions
// Revision: 1.0 - initial release
// ============================================================================
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [31:0]      pc,
  input  logic             exec_done,
  input  logic [1:0]       npc_sel,
  input  logic             branch_taken,
  input  logic [31:0]      rs_val,
  output logic             fetch_fault,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             instr_valid_q, instr_valid_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      w_npc;

  npc_calc u_npc_calc (
    .pc           (pc_q),
    .instr        (instr_q),
    .npc_sel      (npc_sel),
    .branch_taken (branch_taken),
    .rs_val       (rs_val),
    .npc          (w_npc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      cnt_q         <= cnt_d;
    end
  end

  // rvalid is only honoured in S_FETCH and exec_done only in S_ISSUE, so a
  // stray pulse in any other state cannot load a word or retire twice.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    cnt_d         = cnt_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_rvalid) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (exec_done) begin
          pc_d          = w_npc;
          instr_valid_d = 1'b0;
          cnt_d         = cnt_q + CNT_ONE;
          if (is_word_aligned(w_npc)) begin
            state_d = S_FETCH;
          end else begin
            // Faulting address is kept in pc for diagnosis; only rst exits.
            fault_d = 1'b1;
            state_d = S_FAULT;
          end
        end
      end
      S_FAULT: begin
        instr_valid_d = 1'b0;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign fetch_fault = fault_q;
  assign retired_cnt = cnt_q;

endmodule : pc_fetch_unit
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_fetch_unit
// Purpose : Directed self-checking bench for pc_fetch_unit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        exec_done = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic        branch_taken = 1'b0;
  logic [31:0] rs_val = 32'd0;
  logic        fetch_fault;
  logic [31:0] retired_cnt;

  int total = 0;
  int bad   = 0;

  pc_fetch_unit #(
    .RESET_PC (32'h0040_0000),
    .CNT_W    (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .pc           (pc),
    .exec_done    (exec_done),
    .npc_sel      (npc_sel),
    .branch_taken (branch_taken),
    .rs_val       (rs_val),
    .fetch_fault  (fetch_fault),
    .retired_cnt  (retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called while in S_FETCH: wait lat cycles, then return the word.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word, input int lat);
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, addr);
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_ivalid", {31'd0, instr_valid}, 32'd0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    tick();
    imem_rvalid = 1'b0;
    chk("issue_valid", {31'd0, instr_valid}, 32'd1);
    chk("issue_instr", instr, word);
    chk("issue_pc", pc, addr);
    chk("issue_req", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic retire(input logic [1:0] sel, input logic taken, input logic [31:0] rs,
                        input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
    exec_done    = 1'b1;
    npc_sel      = sel;
    branch_taken = taken;
    rs_val       = rs;
    tick();
    exec_done    = 1'b0;
    chk("ret_pc", pc, exp_pc);
    chk("ret_cnt", retired_cnt, exp_cnt);
    chk("ret_ivalid", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    // 1: reset held 3 cycles, zero-latency memory
    tick(); tick(); tick();
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_instr", instr, 32'd0);
    chk("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_cnt", retired_cnt, 32'd0);
    rst = 1'b0;
    tick();  // S_BOOT -> S_FETCH
    chk("boot_ivalid", {31'd0, instr_valid}, 32'd0);
    do_fetch(32'h0040_0000, 32'h0000_0000, 0);

    // stray rvalid in S_ISSUE must not reload instr
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hAAAA_5555;
    tick();
    imem_rvalid = 1'b0;
    chk("issue_rvalid_ign", instr, 32'h0000_0000);
    chk("issue_hold_valid", {31'd0, instr_valid}, 32'd1);

    // 2: sequential retire
    retire(2'b00, 1'b0, 32'd0, 32'h0040_0004, 32'd1);
    chk("seq_addr", imem_addr, 32'h0040_0004);
    chk("seq_req", {31'd0, imem_req}, 32'd1);
    // exec_done held into S_FETCH is not counted again
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("no_double_cnt", retired_cnt, 32'd1);
    chk("fetch_stays", {31'd0, imem_req}, 32'd1);

    do_fetch(32'h0040_0004, 32'h2108_0001, 2);
    retire(2'b00, 1'b0, 32'd0, 32'h0040_0008, 32'd2);
    do_fetch(32'h0040_0008, 32'h2108_0002, 1);
    retire(2'b00, 1'b0, 32'd0, 32'h0040_000C, 32'd3);
    do_fetch(32'h0040_000C, 32'h2108_0003, 0);
    retire(2'b00, 1'b0, 32'd0, 32'h0040_0010, 32'd4);

    // 3: branch with offset -1 word: taken loops to itself, untaken falls through
    do_fetch(32'h0040_0010, 32'h1000_FFFF, 0);
    retire(2'b10, 1'b1, 32'd0, 32'h0040_0010, 32'd5);
    do_fetch(32'h0040_0010, 32'h1000_FFFF, 0);
    retire(2'b10, 1'b0, 32'd0, 32'h0040_0014, 32'd6);
    do_fetch(32'h0040_0014, 32'h0000_0000, 0);
    retire(2'b00, 1'b0, 32'd0, 32'h0040_0018, 32'd7);
    do_fetch(32'h0040_0018, 32'h0000_0000, 0);
    retire(2'b00, 1'b0, 32'd0, 32'h0040_001C, 32'd8);
    do_fetch(32'h0040_001C, 32'h0000_0000, 0);
    retire(2'b00, 1'b0, 32'd0, 32'h0040_0020, 32'd9);

    // 4: j to itself, then jr to 0x00400100
    do_fetch(32'h0040_0020, 32'h0810_0008, 0);
    retire(2'b11, 1'b0, 32'd0, 32'h0040_0020, 32'd10);
    do_fetch(32'h0040_0020, 32'h03E0_0008, 0);
    retire(2'b01, 1'b0, 32'h0040_0100, 32'h0040_0100, 32'd11);

    // 5: misaligned jr target -> sticky fault
    do_fetch(32'h0040_0100, 32'h03E0_0008, 0);
    retire(2'b01, 1'b0, 32'h0040_0102, 32'h0040_0102, 32'd12);
    chk("fault_set", {31'd0, fetch_fault}, 32'd1);
    chk("fault_req", {31'd0, imem_req}, 32'd0);
    exec_done   = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    for (int i = 0; i < 3; i++) tick();
    chk("fault_cnt_hold", retired_cnt, 32'd12);
    chk("fault_pc_hold", pc, 32'h0040_0102);
    chk("fault_req_hold", {31'd0, imem_req}, 32'd0);
    chk("fault_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);
    chk("fault_instr", instr, 32'h03E0_0008);

    // 6: reset out of fault (rst wins over exec_done/rvalid), then
    //    reset during a 5-cycle fetch with a stale rvalid in S_BOOT
    rst = 1'b1;
    tick();
    exec_done   = 1'b0;
    imem_rvalid = 1'b0;
    rst = 1'b0;
    chk("rst2_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst2_pc", pc, 32'h0040_0000);
    chk("rst2_cnt", retired_cnt, 32'd0);
    tick();  // -> S_FETCH
    chk("lat_req", {31'd0, imem_req}, 32'd1);
    tick();  // wait cycle 1
    tick();  // wait cycle 2
    rst = 1'b1;  // asserted in the 3rd wait cycle
    tick();
    rst = 1'b0;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;   // late response lands in S_BOOT
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("stale_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("stale_instr", instr, 32'd0);
    do_fetch(32'h0040_0000, 32'h2400_0001, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pc_fetch_unit
`default_nettype wire
